// File: rtl/ins_cache_multiline.sv
// Direct-mapped multi-line instruction cache between fetch and instruction memory.
// Hits return combinationally; a miss stalls fetch and refills a whole line over req/ack.
module ins_cache_multiline #(
  parameter int unsigned dataW     = 32,
  parameter int unsigned LineWords = 8,
  parameter int unsigned Lines     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  input  logic [dataW-1:0] InsReadInp,
  input  logic             InsReadAck,
  output logic             InsReadReq,
  output logic [dataW-1:0] InsCacheReadAddr,
  output logic             InsCacheStall,
  output logic [dataW-1:0] OutputIns
);

  localparam int unsigned OB     = $clog2(LineWords);
  localparam int unsigned IB     = $clog2(Lines);
  localparam int unsigned IdxW   = (IB > 0) ? IB : 1;
  localparam int unsigned TagLsb = OB + IB + 2;
  localparam int unsigned TagW   = dataW - TagLsb;

  typedef enum logic {
    IDLE,
    REFILL
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [OB-1:0]     count;
  logic [OB-1:0]     countNext;
  logic [OB-1:0]     countInc;
  logic [dataW-1:0]  refillBase;
  logic [dataW-1:0]  baseNext;
  logic [dataW-1:0]  lineBase;
  logic              reqNext;
  logic [dataW-1:0]  addrNext;
  logic              startRefill;
  logic              wordWe;
  logic              lineDone;
  logic              lineHit;

  logic [Lines-1:0]  valid;
  logic [TagW-1:0]   tagMem  [Lines];
  logic [dataW-1:0]  dataMem [Lines][LineWords];

  logic [OB-1:0]     reqWord;
  logic [IdxW-1:0]   reqIdx;
  logic [TagW-1:0]   reqTag;
  logic [IdxW-1:0]   refillIdx;
  logic [TagW-1:0]   refillTag;
  logic              unusedByteBits;

  // Address split for the current fetch and for the latched refill line
  assign reqWord        = ProgAddr[OB+1:2];
  assign reqTag         = ProgAddr[dataW-1:TagLsb];
  assign refillTag      = refillBase[dataW-1:TagLsb];
  assign unusedByteBits = ^ProgAddr[1:0];

  generate
    if (IB > 0) begin : gIdx
      assign reqIdx    = ProgAddr[TagLsb-1:OB+2];
      assign refillIdx = refillBase[TagLsb-1:OB+2];
    end else begin : gNoIdx
      assign reqIdx    = '0;
      assign refillIdx = '0;
    end
  endgenerate

  assign lineBase = ProgAddr & ~dataW'(LineWords * 4 - 1);
  assign countInc = count + OB'(1);

  // Lookup is only trusted while no refill is in flight
  assign lineHit       = (state == IDLE) && valid[reqIdx] && (tagMem[reqIdx] == reqTag);
  assign InsCacheStall = !lineHit;
  assign OutputIns     = lineHit ? dataMem[reqIdx][reqWord] : '0;

  // Next-state and registered-output logic; Flush overrides everything
  always_comb begin
    stateNext   = state;
    countNext   = count;
    baseNext    = refillBase;
    reqNext     = InsReadReq;
    addrNext    = InsCacheReadAddr;
    startRefill = 1'b0;
    wordWe      = 1'b0;
    lineDone    = 1'b0;
    if (Flush) begin
      stateNext = IDLE;
      reqNext   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!lineHit) begin
            stateNext   = REFILL;
            startRefill = 1'b1;
            countNext   = '0;
            baseNext    = lineBase;
            reqNext     = 1'b1;
            addrNext    = lineBase;
          end
        end
        REFILL: begin
          if (InsReadAck) begin
            wordWe    = 1'b1;
            countNext = countInc;
            if (count == OB'(LineWords - 1)) begin
              lineDone  = 1'b1;
              stateNext = IDLE;
              reqNext   = 1'b0;
            end else begin
              addrNext = refillBase | dataW'({countInc, 2'b00});
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      count            <= '0;
      refillBase       <= '0;
      InsReadReq       <= 1'b0;
      InsCacheReadAddr <= '0;
      valid            <= '0;
    end else begin
      state            <= stateNext;
      count            <= countNext;
      refillBase       <= baseNext;
      InsReadReq       <= reqNext;
      InsCacheReadAddr <= addrNext;
      if (Flush) begin
        valid <= '0;
      end else if (startRefill) begin
        valid[reqIdx] <= 1'b0;
      end else if (lineDone) begin
        valid[refillIdx] <= 1'b1;
      end
    end
  end

  // Line storage is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (wordWe) begin
      dataMem[refillIdx][count] <= InsReadInp;
    end
    if (lineDone) begin
      tagMem[refillIdx] <= refillTag;
    end
  end

endmodule

// File: tb/tb_ins_cache_multiline.sv
// Bench for ins_cache_multiline: directed scenarios plus random fetches against
// a line-residency model of a 4-set, 8-word direct-mapped cache.
module tb_ins_cache_multiline;

  logic        clock;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic [31:0] InsReadInp;
  logic        InsReadAck;
  logic        InsReadReq;
  logic [31:0] InsCacheReadAddr;
  logic        InsCacheStall;
  logic [31:0] OutputIns;

  int vectors;
  int miscompares;
  int resident [4];

  ins_cache_multiline #(.dataW(32), .LineWords(8), .Lines(4)) dut (
    .clock(clock),
    .reset(reset),
    .ProgAddr(ProgAddr),
    .Flush(Flush),
    .InsReadInp(InsReadInp),
    .InsReadAck(InsReadAck),
    .InsReadReq(InsReadReq),
    .InsCacheReadAddr(InsCacheReadAddr),
    .InsCacheStall(InsCacheStall),
    .OutputIns(OutputIns)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >= 32'd128) ? (a >> 2) + 32'd100 : (a >> 2);
  endfunction

  function automatic int setOf(input logic [31:0] a);
    return int'((a >> 5) & 32'd3);
  endfunction

  function automatic int lineOf(input logic [31:0] a);
    return int'(a >> 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int s = 0; s < 4; s++) resident[s] = -1;
  endtask

  // mode 0: ack tied high, 1: ack low/high alternating, 2: random ack
  task automatic fetch(input logic [31:0] a, input int mode);
    bit          ackSeq [64];
    bit          miss;
    int          acks;
    int          expStall;
    int          obsStall;
    int          refillCyc;
    logic [31:0] base;
    for (int i = 0; i < 64; i++) begin
      if (mode == 0)      ackSeq[i] = 1'b1;
      else if (mode == 1) ackSeq[i] = (i % 2 == 1);
      else                ackSeq[i] = ($urandom_range(0, 2) != 0) || (i >= 40);
    end
    miss     = (resident[setOf(a)] != lineOf(a));
    expStall = 0;
    if (miss) begin
      acks = 0;
      for (int i = 0; i < 64; i++) begin
        if (ackSeq[i]) acks++;
        if (acks == 8 && expStall == 0) expStall = i + 2;
      end
    end
    base     = a & ~32'h1f;
    ProgAddr = a;
    #1;
    if (miss) begin
      check("missStall", {31'd0, InsCacheStall}, 32'd1);
      check("missOutZero", OutputIns, 32'd0);
    end
    obsStall  = 0;
    refillCyc = 0;
    acks      = 0;
    while (InsCacheStall && obsStall < 200) begin
      if (InsReadReq) begin
        check("refillAddr", InsCacheReadAddr, base + 32'(4 * acks));
        InsReadAck = (refillCyc < 64) ? ackSeq[refillCyc] : 1'b1;
        if (InsReadAck) acks++;
        refillCyc++;
      end else begin
        InsReadAck = 1'b1;
      end
      InsReadInp = mem(InsCacheReadAddr);
      @(posedge clock);
      #1;
      obsStall++;
    end
    InsReadAck = 1'b0;
    check("stallCycles", 32'(obsStall), 32'(expStall));
    check("insData", OutputIns, mem(a & ~32'h3));
    check("reqIdle", {31'd0, InsReadReq}, 32'd0);
    resident[setOf(a)] = lineOf(a);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clearModel();
    reset      = 1'b0;
    Flush      = 1'b0;
    InsReadAck = 1'b0;
    InsReadInp = 32'd0;
    ProgAddr   = 32'd0;
    #12;
    check("rstReq", {31'd0, InsReadReq}, 32'd0);
    check("rstAddr", InsCacheReadAddr, 32'd0);
    check("rstStall", {31'd0, InsCacheStall}, 32'd1);
    check("rstOut", OutputIns, 32'd0);
    reset = 1'b1;

    // Cold miss and hits in the same line
    fetch(32'd0, 0);
    fetch(32'd24, 0);
    fetch(32'd16, 0);
    // Index independence
    fetch(32'd32, 0);
    fetch(32'd4, 0);
    // Conflict eviction
    fetch(32'd128, 0);
    fetch(32'd0, 0);
    // Ack throttling on a fresh conflicting line
    fetch(32'd256, 1);
    fetch(32'd284, 0);

    // Flush after three acked words of a refill
    ProgAddr   = 32'd0;
    InsReadAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InsReadInp = mem(InsCacheReadAddr);
      @(posedge clock);
      #1;
    end
    Flush      = 1'b1;
    InsReadInp = mem(InsCacheReadAddr);
    @(posedge clock);
    #1;
    Flush      = 1'b0;
    InsReadAck = 1'b0;
    clearModel();
    check("flushReqDrop", {31'd0, InsReadReq}, 32'd0);
    ProgAddr = 32'd32;
    #1;
    check("flushIdx1Miss", {31'd0, InsCacheStall}, 32'd1);
    fetch(32'd0, 0);

    // Asynchronous reset in the middle of a refill
    ProgAddr   = 32'd32;
    InsReadAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InsReadInp = mem(InsCacheReadAddr);
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("midRstReq", {31'd0, InsReadReq}, 32'd0);
    check("midRstAddr", InsCacheReadAddr, 32'd0);
    check("midRstStall", {31'd0, InsCacheStall}, 32'd1);
    check("midRstOut", OutputIns, 32'd0);
    #1;
    reset      = 1'b1;
    InsReadAck = 1'b0;
    clearModel();
    fetch(32'd0, 0);

    // Fetch address moves during a refill; the latched line still completes
    ProgAddr   = 32'd64;
    InsReadAck = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) ProgAddr = 32'd8;
      InsReadInp = mem(InsCacheReadAddr);
      @(posedge clock);
      #1;
    end
    InsReadAck = 1'b0;
    check("movedStall", {31'd0, InsCacheStall}, 32'd0);
    check("movedOut", OutputIns, mem(32'd8));
    resident[2] = 2;
    fetch(32'd68, 0);

    // Random fetches with random ack behaviour
    for (int n = 0; n < 40; n++) begin
      fetch(32'($urandom_range(0, 511)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
